// File: rtl/lbuf_cpl_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lbuf_cpl_ctrl_pkg
// Description : Shared types and constants for the lbuf completion controller.
// Revision    : 1.0 - initial release
// ============================================================================
package lbuf_cpl_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ISSUE    = 3'd1,
        ST_BUSY     = 3'd2,
        ST_CPL_REQ  = 3'd3,
        ST_CPL_WAIT = 3'd4,
        ST_RELEASE  = 3'd5
    } cpl_state_t;

    typedef logic [1:0] slot_t;

    localparam slot_t       SLOT_1             = 2'd1;
    localparam slot_t       SLOT_2             = 2'd2;
    localparam int unsigned CPL_STRIDE_DEFAULT = 8;

    // Slot 2 writes its completion word one stride above slot 1 (mod 2^64).
    function automatic logic [63:0] cpl_slot_addr(input logic [63:0] base,
                                                  input slot_t       slot,
                                                  input logic [63:0] stride);
        return (slot == SLOT_2) ? (base + stride) : base;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lbuf_cpl_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : lbuf_cpl_ctrl
// Description : Alternates two host lbuf slots into the DMA engine and posts a
//               completion word per served lbuf before releasing the slot.
// Revision    : 1.0 - initial release
// ============================================================================
module lbuf_cpl_ctrl
    import lbuf_cpl_ctrl_pkg::*;
#(
    parameter int unsigned CPL_STRIDE = CPL_STRIDE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] lbuf1_addr,
    input  logic [63:0] lbuf2_addr,
    input  logic [31:0] lbuf1_len,
    input  logic [31:0] lbuf2_len,
    input  logic        lbuf1_en,
    input  logic        lbuf2_en,
    output logic        lbuf1_dn,
    output logic        lbuf2_dn,
    input  logic [63:0] cpl_addr,
    output logic [63:0] lbuf_addr,
    output logic [31:0] lbuf_len,
    output logic        lbuf_en,
    output logic        lbuf64b,
    input  logic        lbuf_dn,
    output logic        cpl_req,
    input  logic        cpl_gnt,
    output logic [63:0] cpl_wr_addr,
    output logic [63:0] cpl_wr_data,
    input  logic        cpl_dn
);

    cpl_state_t  state_q, state_d;
    slot_t       next_slot_q;
    logic [63:0] addr_q;
    logic [31:0] len_q;
    logic [31:0] seq_q;
    logic [63:0] cpl_wr_addr_q;
    logic [63:0] cpl_wr_data_q;

    logic        sel_en;
    logic [63:0] sel_addr;
    logic [31:0] sel_len;
    logic        latch_desc;
    logic        latch_cpl;
    logic        do_release;

    // Only the slot whose turn it is can start a transfer.
    assign sel_en   = (next_slot_q == SLOT_1) ? lbuf1_en   : lbuf2_en;
    assign sel_addr = (next_slot_q == SLOT_1) ? lbuf1_addr : lbuf2_addr;
    assign sel_len  = (next_slot_q == SLOT_1) ? lbuf1_len  : lbuf2_len;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            next_slot_q   <= SLOT_1;
            addr_q        <= '0;
            len_q         <= '0;
            seq_q         <= '0;
            cpl_wr_addr_q <= '0;
            cpl_wr_data_q <= '0;
        end else begin
            state_q <= state_d;
            if (latch_desc) begin
                addr_q <= sel_addr;
                len_q  <= sel_len;
            end
            // Completion target and payload are frozen at lbuf_dn so they
            // stay stable for the whole request/wait phase.
            if (latch_cpl) begin
                cpl_wr_addr_q <= cpl_slot_addr(cpl_addr, next_slot_q, 64'(CPL_STRIDE));
                cpl_wr_data_q <= {seq_q, len_q};
            end
            if (do_release) begin
                next_slot_q <= (next_slot_q == SLOT_1) ? SLOT_2 : SLOT_1;
                seq_q       <= seq_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        latch_desc  = 1'b0;
        latch_cpl   = 1'b0;
        do_release  = 1'b0;
        lbuf_en     = 1'b0;
        lbuf_addr   = '0;
        lbuf_len    = '0;
        lbuf64b     = 1'b0;
        cpl_req     = 1'b0;
        cpl_wr_addr = '0;
        cpl_wr_data = '0;
        lbuf1_dn    = 1'b0;
        lbuf2_dn    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (sel_en) begin
                    latch_desc = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: state_d = ST_BUSY;
            ST_BUSY: begin
                if (lbuf_dn) begin
                    latch_cpl = 1'b1;
                    state_d   = (cpl_addr == 64'd0) ? ST_RELEASE : ST_CPL_REQ;
                end
            end
            ST_CPL_REQ: begin
                if (cpl_gnt) begin
                    state_d = cpl_dn ? ST_RELEASE : ST_CPL_WAIT;
                end
            end
            ST_CPL_WAIT: begin
                if (cpl_dn) begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                do_release = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are forced low for the whole reset interval.
        if (!rst) begin
            if (state_q == ST_ISSUE || state_q == ST_BUSY) begin
                lbuf_en   = 1'b1;
                lbuf_addr = addr_q;
                lbuf_len  = len_q;
                lbuf64b   = |addr_q[63:32];
            end
            if (state_q == ST_CPL_REQ || state_q == ST_CPL_WAIT) begin
                cpl_wr_addr = cpl_wr_addr_q;
                cpl_wr_data = cpl_wr_data_q;
            end
            cpl_req = (state_q == ST_CPL_REQ);
            if (state_q == ST_RELEASE) begin
                lbuf1_dn = (next_slot_q == SLOT_1);
                lbuf2_dn = (next_slot_q == SLOT_2);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lbuf_cpl_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_lbuf_cpl_ctrl
// Description : Directed self-checking bench for lbuf_cpl_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lbuf_cpl_ctrl;

    logic        clk;
    logic        rst;
    logic [63:0] lbuf1_addr, lbuf2_addr;
    logic [31:0] lbuf1_len, lbuf2_len;
    logic        lbuf1_en, lbuf2_en;
    logic        lbuf1_dn, lbuf2_dn;
    logic [63:0] cpl_addr;
    logic [63:0] lbuf_addr;
    logic [31:0] lbuf_len;
    logic        lbuf_en, lbuf64b, lbuf_dn;
    logic        cpl_req, cpl_gnt, cpl_dn;
    logic [63:0] cpl_wr_addr, cpl_wr_data;

    int n_tests = 0;
    int n_fail  = 0;

    lbuf_cpl_ctrl #(.CPL_STRIDE(8)) dut (
        .clk(clk), .rst(rst),
        .lbuf1_addr(lbuf1_addr), .lbuf2_addr(lbuf2_addr),
        .lbuf1_len(lbuf1_len), .lbuf2_len(lbuf2_len),
        .lbuf1_en(lbuf1_en), .lbuf2_en(lbuf2_en),
        .lbuf1_dn(lbuf1_dn), .lbuf2_dn(lbuf2_dn),
        .cpl_addr(cpl_addr),
        .lbuf_addr(lbuf_addr), .lbuf_len(lbuf_len), .lbuf_en(lbuf_en),
        .lbuf64b(lbuf64b), .lbuf_dn(lbuf_dn),
        .cpl_req(cpl_req), .cpl_gnt(cpl_gnt),
        .cpl_wr_addr(cpl_wr_addr), .cpl_wr_data(cpl_wr_data), .cpl_dn(cpl_dn)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        lbuf1_addr = '0; lbuf2_addr = '0; lbuf1_len = '0; lbuf2_len = '0;
        lbuf1_en = 1'b0; lbuf2_en = 1'b0; cpl_addr = '0;
        lbuf_dn = 1'b0; cpl_gnt = 1'b0; cpl_dn = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Runs one complete slot service from IDLE back to IDLE; called at a negedge.
    task automatic do_service(input int slot, input logic [63:0] addr, input logic [31:0] len,
                              input logic [63:0] cbase, input logic [63:0] exp_cwa,
                              input logic [63:0] exp_cwd, input int gnt_wait,
                              input bit dn_in_gnt, input int dn_wait, input string tag);
        logic exp64, dn_act, dn_oth;
        exp64    = (addr[63:32] != 32'd0);
        cpl_addr = cbase;
        if (slot == 1) begin lbuf1_addr = addr; lbuf1_len = len; lbuf1_en = 1'b1; end
        else           begin lbuf2_addr = addr; lbuf2_len = len; lbuf2_en = 1'b1; end
        @(negedge clk);
        n_tests++;
        if ({lbuf_en, lbuf64b, lbuf_addr, lbuf_len} !== {1'b1, exp64, addr, len}) begin
            n_fail++;
            $display("FAIL %s issue: en=%b 64b=%b addr=%h len=%h, want en=1 64b=%b addr=%h len=%h",
                     tag, lbuf_en, lbuf64b, lbuf_addr, lbuf_len, exp64, addr, len);
        end
        @(negedge clk);
        n_tests++;
        if ({lbuf_en, cpl_req, lbuf1_dn, lbuf2_dn} !== 4'b1000) begin
            n_fail++;
            $display("FAIL %s busy: en/req/dn1/dn2=%b, want 1000", tag,
                     {lbuf_en, cpl_req, lbuf1_dn, lbuf2_dn});
        end
        lbuf_dn = 1'b1;
        @(negedge clk);
        lbuf_dn = 1'b0;
        n_tests++;
        if (lbuf_en !== 1'b0) begin
            n_fail++;
            $display("FAIL %s en_drop: lbuf_en=%b, want 0", tag, lbuf_en);
        end
        if (cbase != 64'd0) begin
            for (int i = 0; i <= gnt_wait; i++) begin
                n_tests++;
                if ({cpl_req, lbuf1_dn, lbuf2_dn, cpl_wr_addr, cpl_wr_data} !==
                    {3'b100, exp_cwa, exp_cwd}) begin
                    n_fail++;
                    $display("FAIL %s cpl_req cyc%0d: req=%b dn=%b%b addr=%h data=%h, want req=1 addr=%h data=%h",
                             tag, i, cpl_req, lbuf1_dn, lbuf2_dn, cpl_wr_addr, cpl_wr_data, exp_cwa, exp_cwd);
                end
                if (i == gnt_wait) begin cpl_gnt = 1'b1; cpl_dn = dn_in_gnt; end
                @(negedge clk);
            end
            cpl_gnt = 1'b0;
            cpl_dn  = 1'b0;
            if (!dn_in_gnt) begin
                for (int i = 0; i <= dn_wait; i++) begin
                    n_tests++;
                    if ({cpl_req, lbuf1_dn, lbuf2_dn, cpl_wr_addr, cpl_wr_data} !==
                        {3'b000, exp_cwa, exp_cwd}) begin
                        n_fail++;
                        $display("FAIL %s cpl_wait cyc%0d: req=%b dn=%b%b addr=%h data=%h, want req=0 addr=%h data=%h",
                                 tag, i, cpl_req, lbuf1_dn, lbuf2_dn, cpl_wr_addr, cpl_wr_data, exp_cwa, exp_cwd);
                    end
                    if (i == dn_wait) cpl_dn = 1'b1;
                    @(negedge clk);
                end
                cpl_dn = 1'b0;
            end
        end
        dn_act = (slot == 1) ? lbuf1_dn : lbuf2_dn;
        dn_oth = (slot == 1) ? lbuf2_dn : lbuf1_dn;
        n_tests++;
        if ({dn_act, dn_oth, cpl_req, lbuf_en} !== 4'b1000) begin
            n_fail++;
            $display("FAIL %s release: dn_slot/dn_other/req/en=%b, want 1000", tag,
                     {dn_act, dn_oth, cpl_req, lbuf_en});
        end
        if (slot == 1) lbuf1_en = 1'b0; else lbuf2_en = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({lbuf1_dn, lbuf2_dn, lbuf_en, cpl_req} !== 4'b0000) begin
            n_fail++;
            $display("FAIL %s post_release: dn1/dn2/en/req=%b, want 0000", tag,
                     {lbuf1_dn, lbuf2_dn, lbuf_en, cpl_req});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        lbuf1_en = 1'b1; lbuf2_en = 1'b1; lbuf_dn = 1'b1; cpl_gnt = 1'b1; cpl_dn = 1'b1;
        lbuf1_addr = 64'hFFFF_FFFF_FFFF_FFFF; cpl_addr = 64'h1000;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if ({lbuf_en, lbuf64b, cpl_req, lbuf1_dn, lbuf2_dn, lbuf_addr, lbuf_len,
                 cpl_wr_addr, cpl_wr_data} !== '0) begin
                n_fail++;
                $display("FAIL reset cyc%0d: en=%b 64b=%b req=%b dn=%b%b addr=%h len=%h wa=%h wd=%h, want all 0",
                         i, lbuf_en, lbuf64b, cpl_req, lbuf1_dn, lbuf2_dn, lbuf_addr, lbuf_len,
                         cpl_wr_addr, cpl_wr_data);
            end
        end
        clear_inputs();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_service(1, 64'h0000_0001_0000_0000, 32'h0020_0000, 64'h1000,
                   64'h1000, 64'h0000_0000_0020_0000, 0, 1'b1, 0, "basic");
    endtask

    task automatic test_alternation();
        apply_reset();
        lbuf2_addr = 64'h0000_0000_9000_0000; lbuf2_len = 32'h40; lbuf2_en = 1'b1;
        do_service(1, 64'h0000_0000_8000_0000, 32'h100, 64'h1000,
                   64'h1000, 64'h0000_0000_0000_0100, 0, 1'b1, 0, "alt_s1");
        do_service(2, 64'h0000_0000_9000_0000, 32'h40, 64'h1000,
                   64'h1008, 64'h0000_0001_0000_0040, 0, 1'b1, 0, "alt_s2");
    endtask

    // Slot 1 is next: slot-2 enable and stray handshake pulses must do nothing.
    task automatic test_ignore();
        lbuf2_addr = 64'h7777; lbuf2_len = 32'h77; lbuf2_en = 1'b1; cpl_addr = 64'h1000;
        for (int i = 0; i < 4; i++) begin
            lbuf_dn = i[0]; cpl_gnt = ~i[0]; cpl_dn = 1'b1;
            @(negedge clk);
            n_tests++;
            if ({lbuf_en, cpl_req, lbuf1_dn, lbuf2_dn} !== 4'b0000) begin
                n_fail++;
                $display("FAIL ignore cyc%0d: en/req/dn1/dn2=%b, want 0000", i,
                         {lbuf_en, cpl_req, lbuf1_dn, lbuf2_dn});
            end
        end
        clear_inputs();
    endtask

    task automatic test_no_cpl();
        do_service(1, 64'hABCD_0000_0000_1000, 32'h0, 64'h0,
                   64'h0, 64'h0, 0, 1'b1, 0, "no_cpl");
    endtask

    task automatic test_gnt_stall();
        do_service(2, 64'h0000_0000_0000_2000, 32'h0000_1234, 64'h2000,
                   64'h2008, 64'h0000_0003_0000_1234, 50, 1'b1, 0, "stall50");
        do_service(1, 64'h0000_0010_0000_0000, 32'hDEAD_BEEF, 64'h2000,
                   64'h2000, 64'h0000_0004_DEAD_BEEF, 2, 1'b0, 3, "cpl_wait");
    endtask

    task automatic test_seq_wrap();
        dut.seq_q = 32'hFFFF_FFFF;
        do_service(2, 64'h4000, 32'h10, 64'hFFFF_FFFF_FFFF_FFFC,
                   64'h0000_0000_0000_0004, 64'hFFFF_FFFF_0000_0010, 0, 1'b1, 0, "wrap_ff");
        do_service(1, 64'h5000, 32'h20, 64'h3000,
                   64'h3000, 64'h0000_0000_0000_0020, 0, 1'b1, 0, "wrap_00");
    endtask

    task automatic test_reset_busy();
        lbuf2_addr = 64'h0000_0002_0000_0000; lbuf2_len = 32'h80; lbuf2_en = 1'b1;
        cpl_addr = 64'h1000;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({lbuf_en, lbuf_addr} !== {1'b1, 64'h0000_0002_0000_0000}) begin
            n_fail++;
            $display("FAIL rst_busy pre: en=%b addr=%h, want en=1 addr=0000000200000000",
                     lbuf_en, lbuf_addr);
        end
        rst = 1'b1; lbuf_dn = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({lbuf_en, lbuf64b, cpl_req, lbuf1_dn, lbuf2_dn, lbuf_addr, lbuf_len,
             cpl_wr_addr, cpl_wr_data} !== '0) begin
            n_fail++;
            $display("FAIL rst_busy outputs: en=%b 64b=%b req=%b dn=%b%b addr=%h len=%h, want all 0",
                     lbuf_en, lbuf64b, cpl_req, lbuf1_dn, lbuf2_dn, lbuf_addr, lbuf_len);
        end
        rst = 1'b0;
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_tests++;
            if ({lbuf_en, cpl_req, lbuf1_dn, lbuf2_dn} !== 4'b0000) begin
                n_fail++;
                $display("FAIL rst_busy after cyc%0d: en/req/dn1/dn2=%b, want 0000", i,
                         {lbuf_en, cpl_req, lbuf1_dn, lbuf2_dn});
            end
        end
        do_service(1, 64'h6000, 32'h30, 64'h1000,
                   64'h1000, 64'h0000_0000_0000_0030, 0, 1'b1, 0, "rst_busy_s1");
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_basic();
        test_alternation();
        test_ignore();
        test_no_cpl();
        test_gnt_stall();
        test_seq_wrap();
        test_reset_busy();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
